ann_layer_sequencer: RTL and testbench

ANN_LAYER_SEQUENCER -- requirements
Module: ann_layer_sequencer

---
 rtl/ann_layer_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ann_layer_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ann_layer_sequencer.sv
// ann_layer_sequencer
//   Control sequencer for a layered neural-network datapath. For one inference
//   it requests the input image, then for every layer requests that layer's
//   coefficient bank, clears the accumulators, lets the datapath run until
//   layer_done, and latches the layer outputs before moving on. A wait
//   counter guards every load and every layer run against a stalled partner.
//
// Ports
//   clk          clock
//   n_rst        asynchronous active-low reset
//   start        begin inference (level, sampled in IDLE)
//   abort        synchronous cancel back to IDLE
//   data_loaded  requested image/coefficients are present
//   layer_done   datapath finished the current layer
//   request      one-cycle load request
//   sel          3'b111 = image, otherwise coefficient bank = layer index
//   max_input    input count of the current layer
//   coeff_ready  datapath may consume
//   reset_accum  clear accumulators
//   load_next    0 none, 4 image, k+1 latch outputs of layer k
//   layer_idx    current layer
//   busy         sequencer is not idle
//   done         one-cycle completion pulse
//   error        sticky timeout flag
module ann_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int IMAGE_SIZE = 64,
  parameter int SIZE_W     = 8,
  parameter logic [((NUM_LAYERS > 1) ? (NUM_LAYERS - 1) : 1)*SIZE_W-1:0] LAYER_SIZES = {8'd8, 8'd16},
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              data_loaded,
  input  logic              layer_done,
  output logic              request,
  output logic [2:0]        sel,
  output logic [SIZE_W-1:0] max_input,
  output logic              coeff_ready,
  output logic              reset_accum,
  output logic [2:0]        load_next,
  output logic [2:0]        layer_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_REQ_IMG   = 4'd1;
  localparam logic [3:0] S_WAIT_IMG  = 4'd2;
  localparam logic [3:0] S_LOAD_IMG  = 4'd3;
  localparam logic [3:0] S_REQ_COEF  = 4'd4;
  localparam logic [3:0] S_WAIT_COEF = 4'd5;
  localparam logic [3:0] S_PAUSE     = 4'd6;
  localparam logic [3:0] S_START     = 4'd7;
  localparam logic [3:0] S_RUN       = 4'd8;
  localparam logic [3:0] S_ADVANCE   = 4'd9;
  localparam logic [3:0] S_CHECK     = 4'd10;
  localparam logic [3:0] S_DONE      = 4'd11;
  localparam logic [3:0] S_FAULT     = 4'd12;

  localparam int              NUM_SLICES = (NUM_LAYERS > 1) ? (NUM_LAYERS - 1) : 1;
  localparam logic [2:0]      LAST_IDX   = 3'(NUM_LAYERS);
  localparam bit              TO_EN      = (TIMEOUT != 0);
  // The timeout fires on the last permitted wait cycle, so a wait state is
  // occupied for exactly TIMEOUT cycles before FAULT.
  localparam logic [SIZE_W-1:0] TO_LAST  = SIZE_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [3:0]        state;
  logic [3:0]        state_next;
  logic [SIZE_W-1:0] wait_cnt;
  logic [2:0]        sel_q;
  logic              is_wait;
  logic              timed_out;
  logic              abort_hit;

  assign is_wait   = (state == S_WAIT_IMG) || (state == S_WAIT_COEF) || (state == S_RUN);
  assign timed_out = TO_EN && (wait_cnt == TO_LAST);
  assign abort_hit = abort && (state != S_IDLE);

  // NOTE: combinational blocks assign every output a default first so no
  // path through the case leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (start) state_next = S_REQ_IMG;
      S_REQ_IMG:   state_next = S_WAIT_IMG;
      // The awaited input is tested before the timeout so a coincident
      // arrival still counts as success.
      S_WAIT_IMG:  if (data_loaded) state_next = S_LOAD_IMG;
                   else if (timed_out) state_next = S_FAULT;
      S_LOAD_IMG:  state_next = S_REQ_COEF;
      S_REQ_COEF:  state_next = S_WAIT_COEF;
      S_WAIT_COEF: if (data_loaded) state_next = S_PAUSE;
                   else if (timed_out) state_next = S_FAULT;
      S_PAUSE:     state_next = S_START;
      S_START:     state_next = S_RUN;
      S_RUN:       if (layer_done) state_next = S_ADVANCE;
                   else if (timed_out) state_next = S_FAULT;
      S_ADVANCE:   state_next = S_CHECK;
      S_CHECK:     state_next = (layer_idx == LAST_IDX) ? S_DONE : S_REQ_COEF;
      S_DONE:      state_next = S_IDLE;
      S_FAULT:     if (!start) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (abort_hit) state_next = S_IDLE;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      layer_idx <= 3'd0;
      wait_cnt  <= '0;
      sel_q     <= 3'b111;
      error     <= 1'b0;
    end else begin
      state <= state_next;
      sel_q <= sel;
      // Cleared on every state change, so each wait state starts from zero.
      wait_cnt <= (is_wait && (state_next == state)) ? wait_cnt + 1'b1 : '0;
      if (abort_hit || (state == S_DONE) || (state == S_FAULT)) begin
        layer_idx <= 3'd0;
      end else if (state == S_ADVANCE) begin
        layer_idx <= layer_idx + 3'd1;
      end
      if ((state_next == S_FAULT) && (state != S_FAULT)) begin
        error <= 1'b1;
      end else if ((state == S_IDLE) && start) begin
        error <= 1'b0;
      end
    end
  end

  always_comb begin
    request     = (state == S_REQ_IMG) || (state == S_REQ_COEF);
    reset_accum = (state == S_START);
    coeff_ready = (state == S_RUN) || (state == S_WAIT_IMG);
    done        = (state == S_DONE);
    busy        = (state != S_IDLE);
    sel         = sel_q;
    if (state == S_REQ_IMG) begin
      sel = 3'b111;
    end else if (state == S_REQ_COEF) begin
      sel = layer_idx;
    end
    load_next = 3'd0;
    if (state == S_LOAD_IMG) begin
      load_next = 3'd4;
    end else if (state == S_ADVANCE) begin
      load_next = layer_idx + 3'd1;
    end
  end

  // Layer k>0 consumes the outputs of layer k-1; past the last layer the
  // final slice is held so CHECK/DONE still show a meaningful size.
  always_comb begin
    max_input = SIZE_W'(IMAGE_SIZE);
    if ((NUM_LAYERS > 1) && (layer_idx != 3'd0)) begin
      for (int k = 0; k < NUM_SLICES; k++) begin
        if ((k == int'(layer_idx) - 1) ||
            ((k == NUM_SLICES - 1) && (int'(layer_idx) > NUM_SLICES))) begin
          max_input = LAYER_SIZES[k*SIZE_W +: SIZE_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// tb_ann_layer_sequencer
//   Three sequencer instances share one set of inputs:
//     [0] defaults (3 layers, TIMEOUT 255)
//     [1] 3 layers, TIMEOUT 4 (timeout and coincidence corners)
//     [2] 5 layers, sizes {4,6,10,12}
//   Only the instance under test in a given section is compared; the others
//   are reset before each section.
module tb_ann_layer_sequencer;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic data_loaded = 1'b0;
  logic layer_done = 1'b0;

  always #5 clk = ~clk;

  logic       request_o [3];
  logic [2:0] sel_o     [3];
  logic [7:0] max_o     [3];
  logic       cr_o      [3];
  logic       ra_o      [3];
  logic [2:0] ln_o      [3];
  logic [2:0] idx_o     [3];
  logic       busy_o    [3];
  logic       done_o    [3];
  logic       err_o     [3];

  ann_layer_sequencer #(.NUM_LAYERS(3), .IMAGE_SIZE(64), .SIZE_W(8),
    .LAYER_SIZES({8'd8, 8'd16}), .TIMEOUT(255)) dut_nom (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .data_loaded(data_loaded), .layer_done(layer_done),
    .request(request_o[0]), .sel(sel_o[0]), .max_input(max_o[0]),
    .coeff_ready(cr_o[0]), .reset_accum(ra_o[0]), .load_next(ln_o[0]),
    .layer_idx(idx_o[0]), .busy(busy_o[0]), .done(done_o[0]), .error(err_o[0]));

  ann_layer_sequencer #(.NUM_LAYERS(3), .IMAGE_SIZE(64), .SIZE_W(8),
    .LAYER_SIZES({8'd8, 8'd16}), .TIMEOUT(4)) dut_to (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .data_loaded(data_loaded), .layer_done(layer_done),
    .request(request_o[1]), .sel(sel_o[1]), .max_input(max_o[1]),
    .coeff_ready(cr_o[1]), .reset_accum(ra_o[1]), .load_next(ln_o[1]),
    .layer_idx(idx_o[1]), .busy(busy_o[1]), .done(done_o[1]), .error(err_o[1]));

  ann_layer_sequencer #(.NUM_LAYERS(5), .IMAGE_SIZE(64), .SIZE_W(8),
    .LAYER_SIZES({8'd4, 8'd6, 8'd10, 8'd12}), .TIMEOUT(255)) dut_5 (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .data_loaded(data_loaded), .layer_done(layer_done),
    .request(request_o[2]), .sel(sel_o[2]), .max_input(max_o[2]),
    .coeff_ready(cr_o[2]), .reset_accum(ra_o[2]), .load_next(ln_o[2]),
    .layer_idx(idx_o[2]), .busy(busy_o[2]), .done(done_o[2]), .error(err_o[2]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Input count of layer k for an nl-layer network, from the bench's own tables.
  function automatic logic [7:0] in_size(input int nl, input int k);
    int s3 [2] = '{16, 8};
    int s5 [4] = '{12, 10, 6, 4};
    if (k == 0) return 8'd64;
    if (nl == 3) return 8'(s3[k-1]);
    return 8'(s5[k-1]);
  endfunction

  task automatic check_reset_values(input int d, input string tag);
    check({tag, ".request"},     request_o[d], 0);
    check({tag, ".sel"},         sel_o[d], 7);
    check({tag, ".max_input"},   max_o[d], 64);
    check({tag, ".coeff_ready"}, cr_o[d], 0);
    check({tag, ".reset_accum"}, ra_o[d], 0);
    check({tag, ".load_next"},   ln_o[d], 0);
    check({tag, ".layer_idx"},   idx_o[d], 0);
    check({tag, ".busy"},        busy_o[d], 0);
    check({tag, ".done"},        done_o[d], 0);
    check({tag, ".error"},       err_o[d], 0);
  endtask

  task automatic do_reset();
    start = 1'b0; abort = 1'b0; data_loaded = 1'b0; layer_done = 1'b0;
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Scoreboard: expectations pushed when start is driven, popped as the DUT
  // issues requests and load_next strobes.
  typedef struct {
    logic [2:0] sel;
    logic [7:0] mi;
  } req_t;

  req_t       exp_req [$];
  logic [2:0] exp_ln  [$];

  // mode 0: full run; 1: abort in RUN of at_layer; 2: n_rst pulse in RUN of at_layer
  task automatic run_seq(input int d, input int nl, input int mode, input int at_layer, input string tag);
    int   dl_cnt = 0;
    int   run_cnt = 0;
    int   dones = 0;
    bit   finished = 0;
    req_t r;
    exp_req.delete();
    exp_ln.delete();
    exp_req.push_back('{3'd7, 8'd64});
    exp_ln.push_back(3'd4);
    for (int k = 0; k < nl; k++) begin
      exp_req.push_back('{3'(k), in_size(nl, k)});
      exp_ln.push_back(3'(k + 1));
    end
    start = 1'b1;
    for (int c = 0; c < 2000 && !finished; c++) begin
      @(posedge clk); #1;
      start = 1'b0; data_loaded = 1'b0; layer_done = 1'b0; abort = 1'b0;
      if (dones > 0) begin
        check({tag, ".idle_after_done.busy"}, busy_o[d], 0);
        check({tag, ".idle_after_done.done"}, done_o[d], 0);
        check({tag, ".idle_after_done.layer_idx"}, idx_o[d], 0);
        finished = 1;
      end else begin
        if (request_o[d]) begin
          if (exp_req.size() == 0) begin
            check({tag, ".unexpected_request"}, 1, 0);
          end else begin
            r = exp_req.pop_front();
            check({tag, ".req.sel"}, sel_o[d], r.sel);
            check({tag, ".req.max_input"}, max_o[d], r.mi);
          end
          dl_cnt = 2;
        end else if (dl_cnt > 0) begin
          dl_cnt--;
          if (dl_cnt == 0) data_loaded = 1'b1;
        end
        if (ln_o[d] != 3'd0) begin
          if (exp_ln.size() == 0) check({tag, ".unexpected_load_next"}, ln_o[d], 0);
          else check({tag, ".load_next"}, ln_o[d], exp_ln.pop_front());
        end
        if (done_o[d]) dones++;
        if (ra_o[d]) begin
          run_cnt = 5;
        end else if (run_cnt > 0) begin
          run_cnt--;
          if (mode != 0 && int'(idx_o[d]) == at_layer && run_cnt == 2) begin
            if (mode == 1) begin
              abort = 1'b1;
              @(posedge clk); #1;
              abort = 1'b0;
              check({tag, ".abort.busy"}, busy_o[d], 0);
              check({tag, ".abort.layer_idx"}, idx_o[d], 0);
              check({tag, ".abort.done"}, done_o[d], 0);
              @(posedge clk); #1;
              check({tag, ".abort.stays_idle"}, busy_o[d], 0);
            end else begin
              n_rst = 1'b0;
              #1;
              check_reset_values(d, {tag, ".async_reset"});
              n_rst = 1'b1;
            end
            finished = 1;
          end else if (run_cnt == 0) begin
            layer_done = 1'b1;
          end
        end
      end
    end
    if (!finished) check({tag, ".cycle_budget_expired"}, 1, 0);
    if (mode == 0) begin
      check({tag, ".done_pulses"}, dones, 1);
      check({tag, ".requests_left"}, exp_req.size(), 0);
      check({tag, ".load_next_left"}, exp_ln.size(), 0);
    end else begin
      check({tag, ".no_done"}, dones, 0);
    end
  endtask

  typedef struct {
    logic       st, dl, ld;
    logic       req;
    logic [2:0] sel, ln, idx;
    logic [7:0] mi;
    logic       cr, ra, busy, err;
  } vec_t;

  function automatic vec_t mk(input logic st, dl, ld, req, input logic [2:0] sel, ln, idx,
                              input logic [7:0] mi, input logic cr, ra, busy, err);
    vec_t v;
    v.st = st; v.dl = dl; v.ld = ld; v.req = req; v.sel = sel; v.ln = ln;
    v.idx = idx; v.mi = mi; v.cr = cr; v.ra = ra; v.busy = busy; v.err = err;
    return v;
  endfunction

  vec_t vecs [32];

  initial begin
    // Timeout instance (TIMEOUT=4): image + coefficient request, fault after
    // four WAIT_COEF cycles, start held then dropped, restart clears error,
    // then data_loaded/layer_done arriving on the last permitted wait cycle.
    //                  st dl ld req sel ln idx  mi cr ra bsy err
    vecs[0]  = mk(1, 0, 0, 1, 7, 0, 0, 64, 0, 0, 1, 0); // REQ_IMG
    vecs[1]  = mk(0, 0, 0, 0, 7, 0, 0, 64, 1, 0, 1, 0); // WAIT_IMG
    vecs[2]  = mk(0, 1, 0, 0, 7, 4, 0, 64, 0, 0, 1, 0); // LOAD_IMG
    vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0, 64, 0, 0, 1, 0); // REQ_COEF
    for (int i = 4; i < 8; i++)
      vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 64, 0, 0, 1, 0); // WAIT_COEF x4
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 64, 0, 0, 1, 1); // FAULT
    vecs[9]  = mk(1, 0, 0, 0, 0, 0, 0, 64, 0, 0, 1, 1); // FAULT, start held
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 64, 0, 0, 1, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 64, 0, 0, 0, 1); // IDLE, error sticky
    vecs[12] = mk(1, 0, 0, 1, 7, 0, 0, 64, 0, 0, 1, 0); // restart clears error
    for (int i = 13; i < 17; i++)
      vecs[i] = mk(0, 0, 0, 0, 7, 0, 0, 64, 1, 0, 1, 0); // WAIT_IMG x4
    vecs[17] = mk(0, 1, 0, 0, 7, 4, 0, 64, 0, 0, 1, 0); // coincident load
    vecs[18] = mk(0, 0, 0, 1, 0, 0, 0, 64, 0, 0, 1, 0); // REQ_COEF
    for (int i = 19; i < 23; i++)
      vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 64, 0, 0, 1, 0); // WAIT_COEF x4
    vecs[23] = mk(0, 1, 0, 0, 0, 0, 0, 64, 0, 0, 1, 0); // PAUSE, no error
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 64, 0, 1, 1, 0); // START
    for (int i = 25; i < 29; i++)
      vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 64, 1, 0, 1, 0); // RUN x4
    vecs[29] = mk(0, 0, 1, 0, 0, 1, 0, 64, 0, 0, 1, 0); // ADVANCE on last cycle
    vecs[30] = mk(0, 0, 0, 0, 0, 0, 1, 16, 0, 0, 1, 0); // CHECK
    vecs[31] = mk(0, 0, 0, 1, 1, 0, 1, 16, 0, 0, 1, 0); // REQ_COEF layer 1

    // Reset values while n_rst is held low.
    #12;
    for (int d = 0; d < 3; d++) check_reset_values(d, $sformatf("por%0d", d));
    n_rst = 1'b1;
    @(posedge clk); #1;

    // abort in IDLE is ignored.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort.busy", busy_o[0], 0);
    check("idle_abort.sel", sel_o[0], 7);

    do_reset();
    for (int i = 0; i < 32; i++) begin
      start = vecs[i].st;
      data_loaded = vecs[i].dl;
      layer_done = vecs[i].ld;
      @(posedge clk); #1;
      check($sformatf("vec%0d.request", i),     request_o[1], vecs[i].req);
      check($sformatf("vec%0d.sel", i),         sel_o[1], vecs[i].sel);
      check($sformatf("vec%0d.load_next", i),   ln_o[1], vecs[i].ln);
      check($sformatf("vec%0d.layer_idx", i),   idx_o[1], vecs[i].idx);
      check($sformatf("vec%0d.max_input", i),   max_o[1], vecs[i].mi);
      check($sformatf("vec%0d.coeff_ready", i), cr_o[1], vecs[i].cr);
      check($sformatf("vec%0d.reset_accum", i), ra_o[1], vecs[i].ra);
      check($sformatf("vec%0d.busy", i),        busy_o[1], vecs[i].busy);
      check($sformatf("vec%0d.error", i),       err_o[1], vecs[i].err);
      check($sformatf("vec%0d.done", i),        done_o[1], 0);
    end

    do_reset();
    run_seq(0, 3, 0, 0, "nominal");
    run_seq(0, 3, 1, 1, "abort_l1");
    run_seq(0, 3, 2, 2, "reset_l2");
    @(posedge clk); #1;
    run_seq(0, 3, 0, 0, "after_reset");

    do_reset();
    run_seq(2, 5, 0, 0, "five_layer");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
